hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It owns every stall, flush, forwarding and PC-select decision. It drives the IF_ID, ID_EX and EX_MEM pipeline registers and the fetch PC mux. A small FSM sequences multi-cycle MDU operations and trap entry/drain, so individual pipeline registers stay purely reactive.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/forwarding_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller:
// FSM states, PC mux selects and operand-forwarding selects.
package pipeline_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP   = 2'd2;
    localparam logic [1:0] PC_SEL_MEPC   = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// No handshakes here: every control output is a same-cycle combinational decision.
interface hazard_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [4:0] i_rs1_d, i_rs2_d;
    logic [4:0] i_rs1_e, i_rs2_e, i_rd_e;
    logic [4:0] i_rd_m, i_rd_w;
    logic       i_mem_read_e;
    logic       i_reg_write_m, i_reg_write_w;
    logic       i_branch_taken_e;
    logic       i_mdu_start_e, i_mdu_done;
    logic       i_exception_m, i_mret_m;

    logic       o_stall_f;
    logic       o_if_id_stall, o_if_id_flush;
    logic       o_id_ex_stall, o_id_ex_flush;
    logic       o_ex_mem_flush;
    logic [1:0] o_fwd_a_e, o_fwd_b_e;
    logic [1:0] o_pc_sel;
    logic       o_trap_pending;
    state_e     o_state;

    modport master (
        output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
               i_mem_read_e, i_reg_write_m, i_reg_write_w, i_branch_taken_e,
               i_mdu_start_e, i_mdu_done, i_exception_m, i_mret_m,
        input  o_stall_f, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
               o_id_ex_flush, o_ex_mem_flush, o_fwd_a_e, o_fwd_b_e,
               o_pc_sel, o_trap_pending, o_state
    );

    modport slave (
        input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
               i_mem_read_e, i_reg_write_m, i_reg_write_w, i_branch_taken_e,
               i_mdu_start_e, i_mdu_done, i_exception_m, i_mret_m,
        output o_stall_f, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
               o_id_ex_flush, o_ex_mem_flush, o_fwd_a_e, o_fwd_b_e,
               o_pc_sel, o_trap_pending, o_state
    );

endinterface

// File: rtl/forwarding_unit.sv
// Operand bypass select for one Execute source: Memory result beats Writeback,
// and x0 is never forwarded.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/PC-select controller: FSM for MDU waits and trap drain,
// fixed-priority event resolution, and the two operand forwarding units.
module hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TRAP_DRAIN = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clk_en,
    hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(TRAP_DRAIN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;
    logic [1:0]         fwd_a, fwd_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // An exception preempts every state, including an in-progress trap drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.i_exception_m) begin
            state_d = ST_TRAP;
            cnt_d   = DRAIN_LOAD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.i_mdu_start_e && !bus.i_mret_m) state_d = ST_MDU_WAIT;
                end
                ST_MDU_WAIT: begin
                    if (bus.i_mdu_done) state_d = ST_RUN;
                end
                ST_TRAP: begin
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign load_use = bus.i_mem_read_e && (bus.i_rd_e != 5'd0) &&
                      ((bus.i_rd_e == bus.i_rs1_d) || (bus.i_rd_e == bus.i_rs2_d));

    always_comb begin
        bus.o_stall_f      = 1'b0;
        bus.o_if_id_stall  = 1'b0;
        bus.o_if_id_flush  = 1'b0;
        bus.o_id_ex_stall  = 1'b0;
        bus.o_id_ex_flush  = 1'b0;
        bus.o_ex_mem_flush = 1'b0;
        bus.o_pc_sel       = PC_SEL_PC4;
        if (!i_rst_n) begin
            bus.o_pc_sel = PC_SEL_PC4;
        end else if (bus.i_exception_m) begin
            bus.o_pc_sel       = PC_SEL_TRAP;
            bus.o_if_id_flush  = 1'b1;
            bus.o_id_ex_flush  = 1'b1;
            bus.o_ex_mem_flush = 1'b1;
        end else if (state_q == ST_TRAP) begin
            bus.o_stall_f     = 1'b1;
            bus.o_if_id_flush = 1'b1;
        end else if (bus.i_mret_m && (state_q == ST_RUN)) begin
            bus.o_pc_sel       = PC_SEL_MEPC;
            bus.o_if_id_flush  = 1'b1;
            bus.o_id_ex_flush  = 1'b1;
            bus.o_ex_mem_flush = 1'b1;
        end else if (bus.i_branch_taken_e) begin
            bus.o_pc_sel      = PC_SEL_BRANCH;
            bus.o_if_id_flush = 1'b1;
            bus.o_id_ex_flush = 1'b1;
        end else if ((state_q == ST_MDU_WAIT) && !bus.i_mdu_done) begin
            bus.o_stall_f      = 1'b1;
            bus.o_if_id_stall  = 1'b1;
            bus.o_id_ex_stall  = 1'b1;
            bus.o_ex_mem_flush = 1'b1;
        end else if (load_use) begin
            bus.o_stall_f     = 1'b1;
            bus.o_if_id_stall = 1'b1;
            bus.o_id_ex_flush = 1'b1;
        end
    end

    forwarding_unit u_fwd_a (
        .rs          (bus.i_rs1_e),
        .rd_m        (bus.i_rd_m),
        .rd_w        (bus.i_rd_w),
        .reg_write_m (bus.i_reg_write_m),
        .reg_write_w (bus.i_reg_write_w),
        .fwd         (fwd_a)
    );

    forwarding_unit u_fwd_b (
        .rs          (bus.i_rs2_e),
        .rd_m        (bus.i_rd_m),
        .rd_w        (bus.i_rd_w),
        .reg_write_m (bus.i_reg_write_m),
        .reg_write_w (bus.i_reg_write_w),
        .fwd         (fwd_b)
    );

    assign bus.o_fwd_a_e      = i_rst_n ? fwd_a : FWD_RF;
    assign bus.o_fwd_b_e      = i_rst_n ? fwd_b : FWD_RF;
    assign bus.o_trap_pending = i_rst_n && (state_q == ST_TRAP);
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: control vectors packed as
// {stall_f, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, pc_sel[1:0]}.
module tb_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk, rst_n, clk_en;
    int   n_checks = 0;
    int   n_pass   = 0;

    hazard_ctrl_if hif ();
    hazard_ctrl_if hif1 ();

    hazard_ctrl #(.TRAP_DRAIN(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .bus(hif.slave)
    );

    hazard_ctrl #(.TRAP_DRAIN(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .bus(hif1.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ctl();
        return {hif.o_stall_f, hif.o_if_id_stall, hif.o_if_id_flush, hif.o_id_ex_stall,
                hif.o_id_ex_flush, hif.o_ex_mem_flush, hif.o_pc_sel};
    endfunction

    // driver tasks
    task automatic clear_inputs();
        hif.i_rs1_d = 0; hif.i_rs2_d = 0; hif.i_rs1_e = 0; hif.i_rs2_e = 0;
        hif.i_rd_e = 0; hif.i_rd_m = 0; hif.i_rd_w = 0;
        hif.i_mem_read_e = 0; hif.i_reg_write_m = 0; hif.i_reg_write_w = 0;
        hif.i_branch_taken_e = 0; hif.i_mdu_start_e = 0; hif.i_mdu_done = 0;
        hif.i_exception_m = 0; hif.i_mret_m = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    localparam logic [7:0] V_IDLE   = 8'b0000_0000;
    localparam logic [7:0] V_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] V_BRANCH = 8'b0010_1001;
    localparam logic [7:0] V_MRET   = 8'b0010_1111;
    localparam logic [7:0] V_MDU    = 8'b1101_0100;
    localparam logic [7:0] V_EXC    = 8'b0010_1110;
    localparam logic [7:0] V_TRAP   = 8'b1010_0000;

    initial begin
        rst_n = 1'b0;
        clk_en = 1'b1;
        clear_inputs();
        hif1.i_rs1_d = 0; hif1.i_rs2_d = 0; hif1.i_rs1_e = 0; hif1.i_rs2_e = 0;
        hif1.i_rd_e = 0; hif1.i_rd_m = 0; hif1.i_rd_w = 0;
        hif1.i_mem_read_e = 0; hif1.i_reg_write_m = 0; hif1.i_reg_write_w = 0;
        hif1.i_branch_taken_e = 0; hif1.i_mdu_start_e = 0; hif1.i_mdu_done = 0;
        hif1.i_exception_m = 0; hif1.i_mret_m = 0;

        // in reset every output is forced low even with hazards on the inputs
        #2;
        hif.i_mem_read_e = 1; hif.i_rd_e = 5; hif.i_rs2_d = 5;
        hif.i_reg_write_m = 1; hif.i_rd_m = 7; hif.i_rs1_e = 7; hif.i_branch_taken_e = 1;
        settle();
        check("reset_ctl", ctl(), V_IDLE);
        check("reset_fwd", {4'd0, hif.o_fwd_a_e, hif.o_fwd_b_e}, 8'd0);
        check("reset_state", 8'(hif.o_state), 8'(ST_RUN));
        check("reset_trap_pending", 8'(hif.o_trap_pending), 8'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        settle();
        check("post_reset_ctl", ctl(), V_IDLE);

        // load-use
        hif.i_mem_read_e = 1; hif.i_rd_e = 5; hif.i_rs2_d = 5;
        settle();
        check("load_use_rs2", ctl(), V_LDUSE);
        tick();
        hif.i_rs2_d = 0; hif.i_rs1_d = 3; hif.i_rd_e = 3;
        settle();
        check("load_use_rs1", ctl(), V_LDUSE);
        hif.i_rd_e = 0; hif.i_rs1_d = 0;
        settle();
        check("load_use_x0", ctl(), V_IDLE);
        hif.i_rd_e = 5; hif.i_rs2_d = 5; hif.i_mem_read_e = 0;
        settle();
        check("no_load_no_stall", ctl(), V_IDLE);
        clear_inputs();

        // forwarding
        hif.i_rd_m = 7; hif.i_rd_w = 7; hif.i_reg_write_m = 1; hif.i_reg_write_w = 1;
        hif.i_rs1_e = 7; hif.i_rs2_e = 2;
        settle();
        check("fwd_a_mem_wins", 8'(hif.o_fwd_a_e), 8'(FWD_MEM));
        check("fwd_b_none", 8'(hif.o_fwd_b_e), 8'(FWD_RF));
        hif.i_reg_write_m = 0; hif.i_rs2_e = 7;
        settle();
        check("fwd_a_wb", 8'(hif.o_fwd_a_e), 8'(FWD_WB));
        check("fwd_b_wb", 8'(hif.o_fwd_b_e), 8'(FWD_WB));
        hif.i_reg_write_m = 1; hif.i_rd_m = 0; hif.i_rd_w = 0; hif.i_rs1_e = 0; hif.i_rs2_e = 0;
        settle();
        check("fwd_x0_never", {4'd0, hif.o_fwd_a_e, hif.o_fwd_b_e}, 8'd0);
        clear_inputs();

        // branch, and branch suppressing load-use
        hif.i_branch_taken_e = 1;
        settle();
        check("branch", ctl(), V_BRANCH);
        hif.i_mem_read_e = 1; hif.i_rd_e = 4; hif.i_rs1_d = 4;
        settle();
        check("branch_over_load_use", ctl(), V_BRANCH);
        clear_inputs();

        // MRET
        hif.i_mret_m = 1; hif.i_branch_taken_e = 1;
        settle();
        check("mret", ctl(), V_MRET);
        tick();
        clear_inputs();
        settle();
        check("mret_state", 8'(hif.o_state), 8'(ST_RUN));

        // clk_en low freezes the FSM
        clk_en = 0; hif.i_mdu_start_e = 1;
        tick();
        hif.i_mdu_start_e = 0;
        settle();
        check("clk_en_freeze", 8'(hif.o_state), 8'(ST_RUN));
        clk_en = 1;

        // MDU: start pulse, 4 stall cycles, done cycle
        hif.i_mdu_start_e = 1;
        settle();
        check("mdu_start_cycle", ctl(), V_IDLE);
        tick();
        hif.i_mdu_start_e = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("mdu_wait_state_%0d", i), 8'(hif.o_state), 8'(ST_MDU_WAIT));
            check($sformatf("mdu_wait_ctl_%0d", i), ctl(), V_MDU);
            tick();
        end
        hif.i_mdu_done = 1;
        settle();
        check("mdu_done_ctl", ctl(), V_IDLE);
        tick();
        hif.i_mdu_done = 0;
        settle();
        check("mdu_done_state", 8'(hif.o_state), 8'(ST_RUN));

        // trap with TRAP_DRAIN=2, including a frozen stretch
        hif.i_exception_m = 1;
        settle();
        check("exc_ctl", ctl(), V_EXC);
        check("exc_not_pending", 8'(hif.o_trap_pending), 8'd0);
        tick();
        hif.i_exception_m = 0;
        clk_en = 0;
        settle();
        check("trap_ctl", ctl(), V_TRAP);
        check("trap_pending", 8'(hif.o_trap_pending), 8'd1);
        tick();
        tick();
        settle();
        check("trap_frozen", 8'(hif.o_state), 8'(ST_TRAP));
        clk_en = 1;
        tick();
        settle();
        check("trap_cycle2", ctl(), V_TRAP);
        check("trap_cycle2_state", 8'(hif.o_state), 8'(ST_TRAP));
        tick();
        settle();
        check("trap_exit_state", 8'(hif.o_state), 8'(ST_RUN));
        check("trap_exit_ctl", ctl(), V_IDLE);

        // exception together with mdu_done during MDU_WAIT, then reload in TRAP
        hif.i_mdu_start_e = 1;
        tick();
        hif.i_mdu_start_e = 0;
        hif.i_mdu_done = 1; hif.i_exception_m = 1;
        settle();
        check("exc_in_mdu_ctl", ctl(), V_EXC);
        tick();
        clear_inputs();
        settle();
        check("exc_over_done_state", 8'(hif.o_state), 8'(ST_TRAP));
        tick();
        hif.i_exception_m = 1;
        settle();
        check("exc_in_trap_ctl", ctl(), V_EXC);
        check("exc_in_trap_pending", 8'(hif.o_trap_pending), 8'd1);
        tick();
        hif.i_exception_m = 0;
        settle();
        check("reload_trap_1", 8'(hif.o_state), 8'(ST_TRAP));
        tick();
        settle();
        check("reload_trap_2", 8'(hif.o_state), 8'(ST_TRAP));
        tick();
        settle();
        check("reload_exit", 8'(hif.o_state), 8'(ST_RUN));

        // simultaneous exception, branch and load-use
        hif.i_exception_m = 1; hif.i_branch_taken_e = 1;
        hif.i_mem_read_e = 1; hif.i_rd_e = 9; hif.i_rs1_d = 9;
        settle();
        check("simultaneous_ctl", ctl(), V_EXC);
        tick();
        clear_inputs();
        tick();
        tick();
        settle();
        check("simultaneous_drained", 8'(hif.o_state), 8'(ST_RUN));

        // asynchronous reset in the middle of MDU_WAIT
        hif.i_mdu_start_e = 1;
        tick();
        hif.i_mdu_start_e = 0;
        hif.i_rs1_e = 3; hif.i_rd_m = 3; hif.i_reg_write_m = 1;
        settle();
        check("pre_reset_mdu", ctl(), V_MDU);
        rst_n = 0;
        settle();
        check("async_reset_ctl", ctl(), V_IDLE);
        check("async_reset_fwd", 8'(hif.o_fwd_a_e), 8'd0);
        check("async_reset_state", 8'(hif.o_state), 8'(ST_RUN));
        tick();
        rst_n = 1;
        clear_inputs();
        tick();
        settle();
        check("after_reset_state", 8'(hif.o_state), 8'(ST_RUN));
        check("after_reset_ctl", ctl(), V_IDLE);

        // TRAP_DRAIN=1: exactly one TRAP cycle
        hif1.i_exception_m = 1;
        tick();
        hif1.i_exception_m = 0;
        settle();
        check("drain1_trap", 8'(hif1.o_state), 8'(ST_TRAP));
        check("drain1_pending", 8'(hif1.o_trap_pending), 8'd1);
        tick();
        settle();
        check("drain1_exit", 8'(hif1.o_state), 8'(ST_RUN));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
